// File: rtl/data_sram_like_resp.sv
// data_sram_like_resp: data-SRAM-like responder backed by a word RAM.
// Accepts req/addr_ok requests and answers in order via data_ok/rdata.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   data_sram_req/wr/size/addr/wstrb/wdata   request from EX stage
//   data_sram_addr_ok     request accepted (with req)
//   data_sram_data_ok     one-cycle response strobe to MEM stage
//   data_sram_rdata       response data, 0 unless data_ok
// Optional macro DSRAM_RAND_STALL_EN: LFSR-driven random stalls on
// addr_ok (lfsr[0]) and head retire (lfsr[1]).
module data_sram_like_resp #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = $clog2(QDEPTH + 1);

  localparam logic [2:0]    LAT_LOAD = 3'(LATENCY - 1);
  localparam logic [CW-1:0] QMAX     = CW'(QDEPTH);
  localparam logic [PW-1:0] PLAST    = PW'(QDEPTH - 1);

  logic [31:0] mem [DEPTH];

  logic [31:0]   data_q [QDEPTH];
  logic [31:0]   data_d [QDEPTH];
  logic [2:0]    cnt_q  [QDEPTH];
  logic [2:0]    cnt_d  [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic misalign;
  logic accept;
  logic retire;
  logic ok_gate;
  logic ret_gate;
  logic unused_addr;

  assign idx = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^data_sram_addr[31:DEPTH_LOG2+2];

  // size 3 is never legal, so it falls into the misaligned bucket
  always_comb begin
    misalign = 1'b0;
    unique case (data_sram_size)
      2'd0: misalign = 1'b0;
      2'd1: misalign = data_sram_addr[0];
      2'd2: misalign = |data_sram_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

`ifdef DSRAM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11
  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign ok_gate  = lfsr_q[0];
  assign ret_gate = lfsr_q[1];
`else
  assign ok_gate  = 1'b1;
  assign ret_gate = 1'b1;
`endif

  // no bypass: a slot freed by this cycle's retire is usable next cycle
  assign data_sram_addr_ok = data_sram_req && (count_q < QMAX) && ok_gate;
  assign accept = data_sram_req && data_sram_addr_ok;
  assign retire = (count_q != '0) && (cnt_q[rptr_q] == 3'd0) && ret_gate;

  assign data_sram_data_ok = retire;
  assign data_sram_rdata   = retire ? data_q[rptr_q] : 32'd0;

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    for (int i = 0; i < QDEPTH; i++) begin
      if (cnt_q[i] != 3'd0) cnt_d[i] = cnt_q[i] - 3'd1;
    end

    // reads sample the RAM before this edge's write; writes cannot
    // coincide with a read accept since one request is taken per cycle
    if (accept) begin
      cnt_d[wptr_q]  = LAT_LOAD;
      data_d[wptr_q] = (data_sram_wr || misalign) ? 32'd0 : mem[idx];
      wptr_d = (wptr_q == PLAST) ? '0 : wptr_q + PW'(1);
    end

    if (retire) begin
      rptr_d = (rptr_q == PLAST) ? '0 : rptr_q + PW'(1);
    end

    unique case ({accept, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        data_q[i] <= 32'd0;
        cnt_q[i]  <= 3'd0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // RAM contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b])
          mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule
